// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two requester ports arbitrated round-robin onto one APB master.
// Optional ACCESS-phase timeout abort is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA0,
    output logic [31:0] RDATA1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [15:0] PSEL,
    output logic [31:0] PADDR,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        BUSY
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]  r_state, w_state_nxt;
    logic        r_last, w_last_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic        w_req0, w_req1, w_pick1, w_timeout;
    logic [15:0] w_psel_nxt;
    logic [31:0] w_paddr_nxt, w_pwdata_nxt, w_rdata0_nxt, w_rdata1_nxt, w_rdata_done;
    logic        w_penable_nxt, w_pwrite_nxt, w_ack0_nxt, w_ack1_nxt;
    logic        w_err0_nxt, w_err1_nxt, w_err_done;

    // A port is invisible to arbitration while its ACK is high.
    assign w_req0  = REQ0 & ~ACK0;
    assign w_req1  = REQ1 & ~ACK1;
    assign w_pick1 = w_req1 & (~w_req0 | ~r_last);

    assign w_rdata_done = (PREADY && !PWRITE) ? PRDATA : 32'h0;
    assign w_err_done   = PREADY ? PSLVERR : 1'b1;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Consecutive PREADY-low cycles in ACCESS.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_ACCESS && !PREADY) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = ~PREADY & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_psel_nxt    = PSEL;
        w_paddr_nxt   = PADDR;
        w_penable_nxt = PENABLE;
        w_pwrite_nxt  = PWRITE;
        w_pwdata_nxt  = PWDATA;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_rdata0_nxt  = RDATA0;
        w_rdata1_nxt  = RDATA1;
        w_err0_nxt    = ERR0;
        w_err1_nxt    = ERR1;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_state_nxt  = ST_SETUP;
                    w_gnt_nxt    = w_pick1;
                    w_last_nxt   = w_pick1;
                    w_paddr_nxt  = w_pick1 ? ADDR1 : ADDR0;
                    w_pwrite_nxt = w_pick1 ? WR1 : WR0;
                    if (w_pwrite_nxt) begin
                        w_pwdata_nxt = w_pick1 ? WDATA1 : WDATA0;
                    end
                    w_psel_nxt = 16'(1) << w_paddr_nxt[27:24];
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY || w_timeout) begin
                    w_state_nxt   = ST_IDLE;
                    w_psel_nxt    = 16'h0;
                    w_penable_nxt = 1'b0;
                    if (r_gnt) begin
                        w_ack1_nxt   = 1'b1;
                        w_rdata1_nxt = w_rdata_done;
                        w_err1_nxt   = w_err_done;
                    end else begin
                        w_ack0_nxt   = 1'b1;
                        w_rdata0_nxt = w_rdata_done;
                        w_err0_nxt   = w_err_done;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = 16'h0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 1'b0;
            PSEL    <= 16'h0;
            PADDR   <= 32'h0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= 32'h0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            RDATA0  <= 32'h0;
            RDATA1  <= 32'h0;
            ERR0    <= 1'b0;
            ERR1    <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_gnt   <= w_gnt_nxt;
            PSEL    <= w_psel_nxt;
            PADDR   <= w_paddr_nxt;
            PENABLE <= w_penable_nxt;
            PWRITE  <= w_pwrite_nxt;
            PWDATA  <= w_pwdata_nxt;
            ACK0    <= w_ack0_nxt;
            ACK1    <= w_ack1_nxt;
            RDATA0  <= w_rdata0_nxt;
            RDATA1  <= w_rdata1_nxt;
            ERR0    <= w_err0_nxt;
            ERR1    <= w_err1_nxt;
            BUSY    <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed and random checks of apb_req_arbiter against a transaction-level model.
// Exercises the timeout abort as well when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

    localparam int unsigned TO = 4;

    logic        PCLK, PRESETN;
    logic        req[2];
    logic        wr[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic        ACK0, ACK1, ERR0, ERR1, PENABLE, PWRITE, BUSY, PREADY, PSLVERR;
    logic [31:0] RDATA0, RDATA1, PADDR, PWDATA, PRDATA;
    logic [15:0] PSEL;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: phase 0 idle, 1 setup, 2 access.
    int          m_ph, m_port, m_wait;
    bit          m_last;
    logic        m_wr;
    logic [31:0] m_addr, m_pwdata;
    logic        m_ack[2];
    logic [31:0] m_rdata[2];
    logic        m_err[2];

    apb_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .REQ0(req[0]), .REQ1(req[1]), .WR0(wr[0]), .WR1(wr[1]),
        .ADDR0(addr[0]), .ADDR1(addr[1]), .WDATA0(wdata[0]), .WDATA1(wdata[1]),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .ERR0(ERR0), .ERR1(ERR1), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .BUSY(BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_port = 0; m_wait = 0; m_last = 1'b1; m_wr = 1'b0;
        m_addr = 32'h0; m_pwdata = 32'h0;
        for (int p = 0; p < 2; p++) begin
            m_ack[p] = 1'b0; m_rdata[p] = 32'h0; m_err[p] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_psel"}, 32'(PSEL), 32'h0);
        chk({tag, "_paddr"}, PADDR, 32'h0);
        chk({tag, "_penable"}, 32'(PENABLE), 32'h0);
        chk({tag, "_pwrite"}, 32'(PWRITE), 32'h0);
        chk({tag, "_pwdata"}, PWDATA, 32'h0);
        chk({tag, "_ack"}, {30'h0, ACK1, ACK0}, 32'h0);
        chk({tag, "_rdata0"}, RDATA0, 32'h0);
        chk({tag, "_rdata1"}, RDATA1, 32'h0);
        chk({tag, "_err"}, {30'h0, ERR1, ERR0}, 32'h0);
        chk({tag, "_busy"}, 32'(BUSY), 32'h0);
    endtask

    // Predict the effect of the coming edge, advance one clock, compare every output.
    task automatic step();
        logic nack[2];
        logic e0, e1;
        int   p;
        nack[0] = 1'b0;
        nack[1] = 1'b0;
        case (m_ph)
            0: begin
                e0 = req[0] && !m_ack[0];
                e1 = req[1] && !m_ack[1];
                if (e0 || e1) begin
                    if (e0 && e1) p = m_last ? 0 : 1;
                    else          p = e0 ? 0 : 1;
                    m_port = p;
                    m_last = (p == 1);
                    m_addr = addr[p];
                    m_wr   = wr[p];
                    if (wr[p]) m_pwdata = wdata[p];
                    m_ph = 1;
                end
            end
            1: begin
                m_ph   = 2;
                m_wait = 0;
            end
            default: begin
                if (PREADY) begin
                    m_ph = 0;
                    nack[m_port]    = 1'b1;
                    m_rdata[m_port] = m_wr ? 32'h0 : PRDATA;
                    m_err[m_port]   = PSLVERR;
                end else begin
                    m_wait++;
`ifdef APB_ARB_TIMEOUT_EN
                    if (m_wait == int'(TO)) begin
                        m_ph = 0;
                        nack[m_port]    = 1'b1;
                        m_rdata[m_port] = 32'h0;
                        m_err[m_port]   = 1'b1;
                    end
`endif
                end
            end
        endcase
        m_ack = nack;
        @(posedge PCLK);
        #1;
        chk("ack0", 32'(ACK0), 32'(m_ack[0]));
        chk("ack1", 32'(ACK1), 32'(m_ack[1]));
        chk("rdata0", RDATA0, m_rdata[0]);
        chk("rdata1", RDATA1, m_rdata[1]);
        chk("err0", 32'(ERR0), 32'(m_err[0]));
        chk("err1", 32'(ERR1), 32'(m_err[1]));
        chk("psel", 32'(PSEL), (m_ph != 0) ? (32'h1 << m_addr[27:24]) : 32'h0);
        chk("penable", 32'(PENABLE), (m_ph == 2) ? 32'h1 : 32'h0);
        chk("busy", 32'(BUSY), (m_ph != 0) ? 32'h1 : 32'h0);
        chk("pwdata", PWDATA, m_pwdata);
        if (m_ph != 0) begin
            chk("paddr", PADDR, m_addr);
            chk("pwrite", 32'(PWRITE), 32'(m_wr));
        end
    endtask

    logic [15:0] seen_psel;
    int          pen_cycles;

    // One isolated transfer on port p with a given number of PREADY-low ACCESS cycles.
    task automatic xfer(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input logic se);
        int edges;
        edges      = 0;
        pen_cycles = 0;
        req[p] = 1'b1; wr[p] = w; addr[p] = a; wdata[p] = d;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_FFFF;
        while (!(p == 1 ? ACK1 : ACK0) && edges < 20) begin
            if (edges >= 2 + waits) begin
                PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
            end else begin
                PREADY = 1'b0;
            end
            step();
            edges++;
            if (edges == 1) seen_psel = PSEL;
            if (PENABLE) pen_cycles++;
        end
        chk("xfer_latency", 32'(edges), 32'(3 + waits));
        chk("xfer_err", 32'(p == 1 ? ERR1 : ERR0), 32'(se));
        chk("xfer_rdata", p == 1 ? RDATA1 : RDATA0, w ? 32'h0 : rd);
        req[p] = 1'b0;
        PREADY = 1'b0;
        step();
    endtask

    initial begin
        int q_order[$];
        int exp_order[3];
        int edges;
        exp_order = '{0, 1, 0};
        PRESETN = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; wr[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(posedge PCLK);
        #1;
        PRESETN = 1'b1;
        step();

        // Write on port 0, no wait states.
        xfer(0, 1'b1, 32'h0300_0010, 32'hA5A5_5A5A, 0, 32'h0, 1'b0);
        chk("wr_psel_setup", 32'(seen_psel), 32'h0000_0008);
        chk("wr_penable_cycles", 32'(pen_cycles), 32'h1);

        // Read on port 1 with three wait states; PWDATA keeps the last write value.
        xfer(1, 1'b0, 32'h0000_0004, 32'h0, 3, 32'h1234_5678, 1'b0);
        chk("rd_pwdata_kept", PWDATA, 32'hA5A5_5A5A);

        // Both ports held: strict alternation starting with port 0.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0100_0000;
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0200_0000;
        PREADY = 1'b1; PRDATA = 32'h0BAD_F00D; PSLVERR = 1'b0;
        for (int c = 0; c < 20 && q_order.size() < 3; c++) begin
            step();
            if (ACK0) q_order.push_back(0);
            if (ACK1) q_order.push_back(1);
        end
        req[0] = 1'b0; req[1] = 1'b0; PREADY = 1'b0;
        step();
        chk("rr_count", 32'(q_order.size()), 32'h3);
        for (int i = 0; i < q_order.size() && i < 3; i++) begin
            chk("rr_order", 32'(q_order[i]), 32'(exp_order[i]));
        end

        // Slave error, then a clean transfer on the same port.
        xfer(0, 1'b0, 32'h0A00_0020, 32'h0, 0, 32'hCAFE_F00D, 1'b1);
        xfer(0, 1'b1, 32'h0A00_0027, 32'h0000_0011, 1, 32'h0, 1'b0);
        chk("paddr_unaligned", PADDR, 32'h0A00_0027);

        // Reset while in ACCESS.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0500_0000; PREADY = 1'b0;
        step();
        step();
        chk("pre_reset_penable", 32'(PENABLE), 32'h1);
        #2;
        PRESETN = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("midreset");
        req[0] = 1'b0;
        @(posedge PCLK);
        #1;
        chk("midreset_no_ack", {30'h0, ACK1, ACK0}, 32'h0);
        PRESETN = 1'b1;
        step();
        step();
        xfer(0, 1'b0, 32'h0600_0000, 32'h0, 0, 32'h5555_AAAA, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
        // PREADY stuck low: abort after TO access cycles.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0700_0000;
        PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
        edges = 0;
        while (!ACK0 && edges < 20) begin
            step();
            edges++;
        end
        chk("to_latency", 32'(edges), 32'(2 + TO));
        chk("to_err", 32'(ERR0), 32'h1);
        chk("to_rdata", RDATA0, 32'h0);
        req[0] = 1'b0;
        step();
`endif

        // Random traffic on both ports against the model.
        for (int c = 0; c < 600; c++) begin
            PREADY  = ($urandom_range(0, 2) != 0);
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 3) == 0);
            step();
            for (int p = 0; p < 2; p++) begin
                if (m_ack[p]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[p] = 1'b0;
                    end else begin
                        wr[p] = 1'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
                    end
                end else if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[p] = 1'b1;
                        wr[p] = 1'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
                    end
                end else if (m_ph != 0 && m_port == p) begin
                    wr[p] = 1'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
                end
            end
        end
        req[0] = 1'b0; req[1] = 1'b0; PREADY = 1'b1;
        for (int c = 0; c < 10 && m_ph != 0; c++) begin
            step();
        end
        step();
        chk("drain_idle", 32'(BUSY), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: PREADY-low cycles before abort; used only when APB_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port PCLK, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port PRESETN, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports REQ0/REQ1, input, 1 each: transfer request; held high until the matching ACK.
REQ-005 SHALL have ports WR0/WR1, input, 1 each: 1 = write, 0 = read.
REQ-006 SHALL have ports ADDR0/ADDR1, input, 32 each: byte address.
REQ-007 SHALL have ports WDATA0/WDATA1, input, 32 each: write data.
REQ-008 SHALL have ports ACK0/ACK1, output, 1 each: one-cycle completion pulse.
REQ-009 SHALL have ports RDATA0/RDATA1, output, 32 each: read data, valid while ACK is high.
REQ-010 SHALL have ports ERR0/ERR1, output, 1 each: error status, valid while ACK is high.
REQ-011 SHALL have port PSEL, output, 16: one-hot APB slot select.
REQ-012 SHALL have port PADDR, output, 32: APB address.
REQ-013 SHALL have port PENABLE, output, 1: APB access phase.
REQ-014 SHALL have port PWRITE, output, 1: APB direction.
REQ-015 SHALL have port PWDATA, output, 32: APB write data.
REQ-016 SHALL have port PRDATA, input, 32: APB read data.
REQ-017 SHALL have port PREADY, input, 1: APB slave ready.
REQ-018 SHALL have port PSLVERR, input, 1: APB slave error.
REQ-019 SHALL have port BUSY, output, 1: high in SETUP or ACCESS.

Function
REQ-020 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-021 In IDLE, SHALL grant a single active REQn, or on a tie the port not most recently served (round-robin), and move to SETUP.
REQ-022 SHALL ignore REQn in the cycle its ACKn is high, so a requester dropping REQ on ACK is never re-granted.
REQ-023 On grant, SHALL latch ADDRn, WRn and WDATAn; requester changes after grant have no effect until ACK.
REQ-024 In SETUP, SHALL drive PSEL bit PADDR[27:24] = 1 (other bits 0) and PENABLE = 0 for exactly one cycle, then move to ACCESS.
REQ-025 In ACCESS, SHALL hold PSEL, PADDR, PWRITE and PWDATA stable with PENABLE = 1 until PREADY = 1 is sampled.
REQ-026 On PREADY = 1 in ACCESS, SHALL return to IDLE with PSEL = 0 and PENABLE = 0.
REQ-027 In the next cycle, SHALL pulse ACKn for the granted port, with RDATAn = sampled PRDATA (reads; 0 for writes) and ERRn = sampled PSLVERR.
REQ-028 Latency SHALL be: REQ high at edge 0 in IDLE, SETUP at edge 1, ACCESS at edge 2, ACK at edge 3 when PREADY = 1, plus one cycle per PREADY-low cycle.
REQ-029 SHALL pass PADDR unmodified, including bits [1:0]; no alignment check.
REQ-030 PWDATA SHALL retain the last write value during reads and idle.
REQ-031 RDATAn and ERRn SHALL hold their values after ACK until the next ACKn for that port.

Reset
REQ-032 On PRESETN low, SHALL asynchronously set state = IDLE; PSEL, PADDR, PENABLE, PWRITE, PWDATA, ACKn, RDATAn, ERRn and BUSY = 0; last-served = port 1, so port 0 wins the first tie.
REQ-033 Reset mid-transfer SHALL drop PSEL and PENABLE immediately, issue no ACK, and discard the in-flight request.

Configuration
REQ-034 With APB_ARB_TIMEOUT_EN defined, SHALL count consecutive ACCESS cycles with PREADY = 0.
REQ-035 When that count reaches TIMEOUT_CYCLES, SHALL abort to IDLE and pulse ACKn with ERRn = 1 and RDATAn = 0.
REQ-036 Without APB_ARB_TIMEOUT_EN, SHALL wait in ACCESS indefinitely; no counter logic exists.

Verification
REQ-037 REQ0 write ADDR0 = 0x0300_0010, WDATA0 = 0xA5A5_5A5A, PREADY = 1 -> PSEL = 0x0008, PWRITE = 1, PENABLE high one cycle, ACK0 at edge 3, ERR0 = 0.
REQ-038 REQ1 read ADDR1 = 0x0000_0004, PREADY low 3 cycles, PRDATA = 0x1234_5678 -> ACK1 at edge 6, RDATA1 = 0x1234_5678.
REQ-039 REQ0 and REQ1 raised in the same cycle and held -> port 0 served, then port 1, then port 0; no back-to-back grant to one port while the other waits.
REQ-040 PSLVERR = 1 with PREADY -> ERRn = 1 on ACK; next transfer with PSLVERR = 0 -> ERRn = 0.
REQ-041 PRESETN low during ACCESS -> PSEL = 0 and PENABLE = 0 asynchronously, no ACK; after release a new REQ0 completes normally.
REQ-042 With APB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 4, PREADY held 0 -> abort after 4 ACCESS cycles, ACKn with ERRn = 1 and RDATAn = 0.
